// File: rtl/addsub_chunked.sv
// -----------------------------------------------------------------------------
// addsub_chunked
//
// Multi-cycle two's-complement adder/subtractor. A WIDTH-bit operand pair is
// consumed CHUNK bits per clock, least-significant chunk first. The carry is
// kept between chunks. The result is returned sign-extended to WIDTH+1 bits,
// together with a WIDTH-bit signed-overflow flag. The host uses a
// start/busy/done handshake.
//
// Parameters
//   WIDTH    operand width (>= 2, integer multiple of CHUNK)
//   CHUNK    bits processed per clock; N = WIDTH/CHUNK cycles per operation
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset
//   start     in   request, sampled in IDLE or DONE only
//   sub       in   0: a+b, 1: a-b (latched with start)
//   a, b      in   signed operands (latched with start)
//   busy      out  high while an operation is running
//   done      out  one-cycle pulse, result valid
//   sum       out  WIDTH+1-bit signed result, held until the next completion
//   overflow  out  WIDTH-bit signed overflow of the last result, held
//
// Build option
//   ADDSUB_SAT_EN  when defined, an overflowing result saturates to the most
//                  positive / most negative WIDTH-bit value (sign-extended);
//                  overflow is still reported. When undefined, sum is the
//                  exact WIDTH+1-bit signed result.
// -----------------------------------------------------------------------------
module addsub_chunked #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum,
  output logic             overflow
);

  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);
  localparam logic [IDXW-1:0] IDX_ZERO = IDXW'(0);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One chunk of the ripple: CHUNK-bit add with carry-in, carry-out on top.
  function automatic logic [CHUNK:0] f_chunk_add(
    input logic [CHUNK-1:0] x,
    input logic [CHUNK-1:0] y,
    input logic             cin
  );
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
  endfunction

  // Carry into the top bit of a chunk, recovered from that bit's operands and
  // sum bit (works for any CHUNK, including CHUNK=1).
  function automatic logic f_carry_into_msb(
    input logic x_msb,
    input logic y_msb,
    input logic s_msb
  );
    return x_msb ^ y_msb ^ s_msb;
  endfunction

  state_t             r_state;
  state_t             w_state_next;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;       // already inverted for subtraction
  logic               r_carry;
  logic [IDXW-1:0]    r_idx;
  logic [WIDTH-1:0]   r_res;     // chunks assembled so far
  logic [WIDTH:0]     r_sum;
  logic               r_ovf;
  logic               r_busy;
  logic               r_done;

  logic               w_load;
  logic               w_step;
  logic               w_is_last;
  logic [CHUNK-1:0]   w_chunk_a;
  logic [CHUNK-1:0]   w_chunk_b;
  logic [CHUNK:0]     w_add;
  logic [CHUNK-1:0]   w_csum;
  logic               w_cout;
  logic               w_cin_msb;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_res_next;
  logic [WIDTH:0]     w_sum_next;

  assign w_is_last = (r_idx == LAST_IDX);

  // Next-state logic and the load/step strobes that drive the datapath.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_RUN;
          w_load       = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        w_step = 1'b1;
        if (w_is_last) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      ST_DONE: begin
        // start in the done cycle launches the next operation directly
        if (start) begin
          w_state_next = ST_RUN;
          w_load       = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Select the current chunk of each operand and add it with the running carry.
  always_comb begin
    w_chunk_a = r_a[int'(r_idx) * CHUNK +: CHUNK];
    w_chunk_b = r_b[int'(r_idx) * CHUNK +: CHUNK];
    w_add     = f_chunk_add(w_chunk_a, w_chunk_b, r_carry);
    w_csum    = w_add[CHUNK-1:0];
    w_cout    = w_add[CHUNK];
    // Only meaningful on the final chunk, where these are bit WIDTH-1 carries.
    w_cin_msb = f_carry_into_msb(w_chunk_a[CHUNK-1], w_chunk_b[CHUNK-1],
                                 w_csum[CHUNK-1]);
    w_ovf     = w_cin_msb ^ w_cout;
  end

  // Merge the freshly computed chunk into the assembled result.
  always_comb begin
    w_res_next = r_res;
    w_res_next[int'(r_idx) * CHUNK +: CHUNK] = w_csum;
  end

  // Final result formatting: exact sign extension, or saturation when built in.
  always_comb begin
    // Flipping the WIDTH-bit sign on overflow yields the true WIDTH+1-bit sign.
    w_sum_next = {w_res_next[WIDTH-1] ^ w_ovf, w_res_next};
`ifdef ADDSUB_SAT_EN
    if (w_ovf) begin
      if (w_cout) begin
        w_sum_next = {2'b11, {(WIDTH-1){1'b0}}};
      end else begin
        w_sum_next = {2'b00, {(WIDTH-1){1'b1}}};
      end
    end else begin
      w_sum_next = {w_res_next[WIDTH-1], w_res_next};
    end
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Registered handshake outputs, decoded from the upcoming state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_next == ST_RUN);
      r_done <= (w_state_next == ST_DONE);
    end
  end

  // Operand capture and per-chunk datapath state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= {WIDTH{1'b0}};
      r_b     <= {WIDTH{1'b0}};
      r_carry <= 1'b0;
      r_idx   <= IDX_ZERO;
      r_res   <= {WIDTH{1'b0}};
    end else if (w_load) begin
      r_a     <= a;
      // a - b is computed as a + ~b + 1, the +1 entering as the first carry
      r_b     <= sub ? ~b : b;
      r_carry <= sub;
      r_idx   <= IDX_ZERO;
      r_res   <= {WIDTH{1'b0}};
    end else if (w_step) begin
      r_res   <= w_res_next;
      r_carry <= w_cout;
      r_idx   <= w_is_last ? IDX_ZERO : (r_idx + IDX_ONE);
    end else begin
      r_a     <= r_a;
      r_b     <= r_b;
      r_carry <= r_carry;
      r_idx   <= r_idx;
      r_res   <= r_res;
    end
  end

  // Result and overflow, updated only on the edge completing the last chunk.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum <= {(WIDTH+1){1'b0}};
      r_ovf <= 1'b0;
    end else if (w_step && w_is_last) begin
      r_sum <= w_sum_next;
      r_ovf <= w_ovf;
    end else begin
      r_sum <= r_sum;
      r_ovf <= r_ovf;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign sum      = r_sum;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_addsub_chunked.sv
module tb_addsub_chunked;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // WIDTH=16, CHUNK=4
  logic        w_start, w_sub, w_busy, w_done, w_ovf;
  logic [15:0] w_a, w_b;
  logic [16:0] w_sum;
  // WIDTH=8, CHUNK=1
  logic        c1_start, c1_sub, c1_busy, c1_done, c1_ovf;
  logic [7:0]  c1_a, c1_b;
  logic [8:0]  c1_sum;
  // WIDTH=8, CHUNK=8
  logic        c8_start, c8_sub, c8_busy, c8_done, c8_ovf;
  logic [7:0]  c8_a, c8_b;
  logic [8:0]  c8_sum;

  addsub_chunked #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(w_start), .sub(w_sub), .a(w_a), .b(w_b),
    .busy(w_busy), .done(w_done), .sum(w_sum), .overflow(w_ovf));

  addsub_chunked #(.WIDTH(8), .CHUNK(1)) dut8c1 (
    .clk(clk), .rst_n(rst_n), .start(c1_start), .sub(c1_sub), .a(c1_a), .b(c1_b),
    .busy(c1_busy), .done(c1_done), .sum(c1_sum), .overflow(c1_ovf));

  addsub_chunked #(.WIDTH(8), .CHUNK(8)) dut8c8 (
    .clk(clk), .rst_n(rst_n), .start(c8_start), .sub(c8_sub), .a(c8_a), .b(c8_b),
    .busy(c8_busy), .done(c8_done), .sum(c8_sum), .overflow(c8_ovf));

  int tests_run = 0;
  int failures  = 0;

  typedef struct packed {
    logic [16:0] sum;
    logic        ovf;
  } exp_t;

  exp_t sbq[$];
  exp_t last_exp;

  // Behavioural signed model for a w-bit operation.
  function automatic exp_t model(input int w, input logic [15:0] a,
                                 input logic [15:0] b, input logic sub);
    int sa, sb, r, maxv, minv;
    exp_t e;
    sa   = a[w-1] ? (int'(a) - (1 << w)) : int'(a);
    sb   = b[w-1] ? (int'(b) - (1 << w)) : int'(b);
    r    = sub ? (sa - sb) : (sa + sb);
    maxv = (1 << (w - 1)) - 1;
    minv = -(1 << (w - 1));
    e.ovf = (r > maxv) || (r < minv);
`ifdef ADDSUB_SAT_EN
    if (r > maxv) r = maxv;
    else if (r < minv) r = minv;
`endif
    e.sum = 17'(r & ((1 << (w + 1)) - 1));
    return e;
  endfunction

  task automatic get_out(input int sel, output logic [16:0] s, output logic o,
                         output logic bsy, output logic dn);
    case (sel)
      0: begin s = w_sum;           o = w_ovf;  bsy = w_busy;  dn = w_done;  end
      1: begin s = {8'd0, c1_sum};  o = c1_ovf; bsy = c1_busy; dn = c1_done; end
      default: begin s = {8'd0, c8_sum}; o = c8_ovf; bsy = c8_busy; dn = c8_done; end
    endcase
  endtask

  task automatic set_in(input int sel, input logic st, input logic [15:0] a,
                        input logic [15:0] b, input logic sb);
    case (sel)
      0: begin w_start = st;  w_a = a;       w_b = b;       w_sub = sb;  end
      1: begin c1_start = st; c1_a = a[7:0]; c1_b = b[7:0]; c1_sub = sb; end
      default: begin c8_start = st; c8_a = a[7:0]; c8_b = b[7:0]; c8_sub = sb; end
    endcase
  endtask

  // Present an operation for one sampling edge (E0); returns at the negedge after E0.
  task automatic launch(input int sel, input logic [15:0] a, input logic [15:0] b,
                        input logic sb);
    @(negedge clk);
    set_in(sel, 1'b1, a, b, sb);
    @(posedge clk);
    @(negedge clk);
    set_in(sel, 1'b0, a, b, sb);
  endtask

  // Count rising edges until done is seen (sampled at negedge); -1 on timeout.
  task automatic wait_done(input int sel, input int limit, output int lat);
    logic [16:0] s;
    logic o, bsy, dn;
    lat = -1;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk);
      @(negedge clk);
      get_out(sel, s, o, bsy, dn);
      if (dn) begin
        lat = k;
        return;
      end
    end
  endtask

  task automatic test_reset();
    logic [16:0] s;
    logic o, bsy, dn;
    rst_n = 1'b0;
    set_in(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    set_in(1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    set_in(2, 1'b0, 16'h0000, 16'h0000, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int sel = 0; sel < 3; sel++) begin
      get_out(sel, s, o, bsy, dn);
      tests_run++;
      if ({s, o, bsy, dn} !== 20'd0) begin
        failures++;
        $display("FAIL reset_state dut%0d: sum=%h ovf=%b busy=%b done=%b, expected all 0",
                 sel, s, o, bsy, dn);
      end
    end
    rst_n = 1'b1;
    last_exp = '0;
  endtask

  task automatic test_basic_vectors();
    logic [15:0] ta[4];
    logic [15:0] tb[4];
    logic        tsub[4];
    logic [16:0] tsum[4];
    logic        tovf[4];
    logic [16:0] s;
    logic o, bsy, dn;
    int lat;
    exp_t e;
    ta   = '{16'h1234, 16'h0005, 16'h7FFF, 16'h8000};
    tb   = '{16'h0F0F, 16'h0007, 16'h0001, 16'h0001};
    tsub = '{1'b0, 1'b1, 1'b0, 1'b1};
`ifdef ADDSUB_SAT_EN
    tsum = '{17'h02143, 17'h1FFFE, 17'h07FFF, 17'h18000};
`else
    tsum = '{17'h02143, 17'h1FFFE, 17'h08000, 17'h17FFF};
`endif
    tovf = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      sbq.push_back({tsum[i], tovf[i]});
      launch(0, ta[i], tb[i], tsub[i]);
      get_out(0, s, o, bsy, dn);
      tests_run++;
      if (bsy !== 1'b1 || dn !== 1'b0) begin
        failures++;
        $display("FAIL vec%0d_busy_after_start: busy=%b done=%b, expected 1/0", i, bsy, dn);
      end
      wait_done(0, 20, lat);
      tests_run++;
      if (lat !== 4) begin
        failures++;
        $display("FAIL vec%0d_latency: got %0d, expected 4", i, lat);
      end
      e = sbq.pop_front();
      get_out(0, s, o, bsy, dn);
      tests_run++;
      if (s !== e.sum || o !== e.ovf || bsy !== 1'b0) begin
        failures++;
        $display("FAIL vec%0d_result: sum=%h ovf=%b busy=%b, expected sum=%h ovf=%b busy=0",
                 i, s, o, bsy, e.sum, e.ovf);
      end
      last_exp = e;
      @(posedge clk);
      @(negedge clk);
      get_out(0, s, o, bsy, dn);
      tests_run++;
      if (dn !== 1'b0 || s !== e.sum || o !== e.ovf) begin
        failures++;
        $display("FAIL vec%0d_done_pulse_hold: done=%b sum=%h ovf=%b, expected done=0 sum=%h ovf=%b",
                 i, dn, s, o, e.sum, e.ovf);
      end
    end
  endtask

  task automatic test_ignore_while_busy();
    logic [16:0] s;
    logic o, bsy, dn;
    int lat;
    exp_t e;
    sbq.push_back(model(16, 16'h1234, 16'h0F0F, 1'b0));
    launch(0, 16'h1234, 16'h0F0F, 1'b0);
    // E0 done; disturb inputs during RUN
    set_in(0, 1'b1, 16'hFFFF, 16'h8001, 1'b1);
    @(posedge clk);
    @(negedge clk);
    get_out(0, s, o, bsy, dn);
    tests_run++;
    if (s !== last_exp.sum || o !== last_exp.ovf || bsy !== 1'b1) begin
      failures++;
      $display("FAIL busy_hold_result: sum=%h ovf=%b busy=%b, expected sum=%h ovf=%b busy=1",
               s, o, bsy, last_exp.sum, last_exp.ovf);
    end
    set_in(0, 1'b1, 16'h0F00, 16'h7777, 1'b0);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    wait_done(0, 20, lat);
    tests_run++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL busy_ignore_latency: got %0d remaining cycles, expected 2", lat);
    end
    e = sbq.pop_front();
    get_out(0, s, o, bsy, dn);
    tests_run++;
    if (s !== e.sum || o !== e.ovf) begin
      failures++;
      $display("FAIL busy_ignore_result: sum=%h ovf=%b, expected sum=%h ovf=%b",
               s, o, e.sum, e.ovf);
    end
    last_exp = e;
    // no spurious relaunch
    wait_done(0, 8, lat);
    tests_run++;
    if (lat !== -1) begin
      failures++;
      $display("FAIL busy_ignore_no_relaunch: done seen after %0d cycles, expected none", lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] s;
    logic o, bsy, dn;
    int lat;
    exp_t e;
    sbq.push_back(model(16, 16'h0100, 16'h0023, 1'b0));
    sbq.push_back(model(16, 16'h4000, 16'h0001, 1'b1));
    @(negedge clk);
    set_in(0, 1'b1, 16'h0100, 16'h0023, 1'b0);
    @(posedge clk);
    @(negedge clk);
    // start stays high; second operands wait for the DONE cycle
    set_in(0, 1'b1, 16'h4000, 16'h0001, 1'b1);
    wait_done(0, 20, lat);
    tests_run++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL b2b_first_latency: got %0d, expected 4", lat);
    end
    e = sbq.pop_front();
    get_out(0, s, o, bsy, dn);
    tests_run++;
    if (s !== e.sum || o !== e.ovf) begin
      failures++;
      $display("FAIL b2b_first_result: sum=%h ovf=%b, expected sum=%h ovf=%b", s, o, e.sum, e.ovf);
    end
    @(posedge clk);
    @(negedge clk);
    set_in(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    get_out(0, s, o, bsy, dn);
    tests_run++;
    if (bsy !== 1'b1 || dn !== 1'b0) begin
      failures++;
      $display("FAIL b2b_relaunch: busy=%b done=%b, expected 1/0", bsy, dn);
    end
    wait_done(0, 20, lat);
    tests_run++;
    if (lat + 1 !== 5) begin
      failures++;
      $display("FAIL b2b_done_spacing: got %0d cycles, expected 5", lat + 1);
    end
    e = sbq.pop_front();
    get_out(0, s, o, bsy, dn);
    tests_run++;
    if (s !== e.sum || o !== e.ovf) begin
      failures++;
      $display("FAIL b2b_second_result: sum=%h ovf=%b, expected sum=%h ovf=%b", s, o, e.sum, e.ovf);
    end
    last_exp = e;
    @(posedge clk);
  endtask

  task automatic test_reset_mid_run();
    logic [16:0] s;
    logic o, bsy, dn;
    int lat;
    launch(0, 16'h7FFF, 16'h7FFF, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    get_out(0, s, o, bsy, dn);
    tests_run++;
    if (s !== 17'd0 || o !== 1'b0 || bsy !== 1'b0 || dn !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_run: sum=%h ovf=%b busy=%b done=%b, expected all 0", s, o, bsy, dn);
    end
    wait_done(0, 10, lat);
    tests_run++;
    if (lat !== -1) begin
      failures++;
      $display("FAIL reset_mid_run_no_done: done seen after %0d cycles, expected none", lat);
    end
    last_exp = '0;
  endtask

  task automatic test_sweep(input int sel, input int n_exp);
    logic [15:0] a, b;
    logic sb;
    logic [16:0] s;
    logic o, bsy, dn;
    int lat;
    exp_t e;
    for (int i = 0; i < 1000; i++) begin
      if (i == 0) begin
        a = 16'h007F; b = 16'h0001; sb = 1'b0;
      end else if (i == 1) begin
        a = 16'h0080; b = 16'h0001; sb = 1'b1;
      end else begin
        a = 16'($urandom_range(0, 255));
        b = 16'($urandom_range(0, 255));
        sb = 1'($urandom_range(0, 1));
      end
      sbq.push_back(model(8, a, b, sb));
      launch(sel, a, b, sb);
      wait_done(sel, 30, lat);
      tests_run++;
      if (lat !== n_exp) begin
        failures++;
        $display("FAIL sweep_dut%0d_latency[%0d]: got %0d, expected %0d", sel, i, lat, n_exp);
      end
      e = sbq.pop_front();
      get_out(sel, s, o, bsy, dn);
      tests_run++;
      if (s !== e.sum || o !== e.ovf) begin
        failures++;
        $display("FAIL sweep_dut%0d_result[%0d]: a=%h b=%h sub=%b sum=%h ovf=%b, expected sum=%h ovf=%b",
                 sel, i, a[7:0], b[7:0], sb, s, o, e.sum, e.ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_vectors();
    test_ignore_while_busy();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep(1, 8);
    test_sweep(2, 1);
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/addsub_chunked.md
# addsub_chunked

Parametrised, multi-cycle two's-complement adder/subtractor. Processes a WIDTH-bit operand pair CHUNK bits per clock, carrying between chunks. Returns a sign-extended WIDTH+1-bit result plus a signed-overflow flag. Intended as the area-scalable replacement for fixed-width single-cycle adder/subtractors in datapaths where latency is acceptable; the host drives it through a start/busy/done handshake.

## Interface
- WIDTH, 16: operand width in bits; must be ≥ 2 and an integer multiple of CHUNK.
- CHUNK, 4: bits processed per cycle; N = WIDTH/CHUNK cycles per operation.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  request; sampled only in IDLE or DONE.
- sub  input  1  0 = a+b, 1 = a−b; latched with start.
- a  input  WIDTH  signed operand A; latched with start.
- b  input  WIDTH  signed operand B; latched with start.
- busy  output  1  high while in RUN.
- done  output  1  single-cycle pulse; result valid.
- sum  output  WIDTH+1  signed result; held until the next completion.
- overflow  output  1  WIDTH-bit signed overflow of the last result; held.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: if start, then:
  - latch a;
  - latch b, or ~b if sub;
  - carry ← sub, chunk index ← 0;
  - go to RUN.
- RUN: each cycle, add chunk[index] of A and B with the carry. Store the CHUNK result bits, update the carry, increment the index. After chunk N−1 completes, go to DONE.
- Updates at the edge that completes the final chunk:
  - sum[WIDTH-1:0] ← assembled result;
  - overflow ← carry into bit WIDTH-1 XOR carry out of bit WIDTH-1;
  - sum[WIDTH] ← sum[WIDTH-1] XOR overflow, giving the exact signed result in WIDTH+1 bits.
- DONE: done=1 for exactly this cycle.
  - start=1 → go straight to RUN with the new operands (back-to-back).
  - Otherwise → IDLE.
- While in RUN:
  - start is ignored;
  - changes on a, b and sub are ignored;
  - sum and overflow keep their previous values.
- Reset, at any point including mid-RUN: state IDLE, busy=0, done=0, sum=0, overflow=0, internal carry/index/operands cleared. An aborted operation never pulses done.

## Timing
- Edge E0 samples start=1: state RUN, busy=1 from E0.
- Edges E1..EN each process one chunk.
- At EN: state DONE, busy=0, done=1, sum/overflow updated.
- At EN+1: done=0.
- Start-to-done latency is N cycles. Throughput with back-to-back start is one operation per N+1 cycles.
- CHUNK=WIDTH gives N=1: done is high in the cycle after start is sampled.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- ADDSUB_SAT_EN defined: on overflow, sum[WIDTH-1:0] saturates:
  - to 0111…1 for positive overflow (carry-out 0);
  - to 1000…0 for negative overflow;
  - sum[WIDTH] equals sum[WIDTH-1];
  - overflow is still reported.
- ADDSUB_SAT_EN undefined: sum is the exact WIDTH+1-bit signed result as described in Operation, with no saturation logic.

## Test plan
All scenarios use WIDTH=16, CHUNK=4 (N=4) unless stated.

1. Add: start with a=0x1234, b=0x0F0F, sub=0 → busy for 4 cycles, then done pulse; sum=0x02143, overflow=0.
2. Subtract: a=0x0005, b=0x0007, sub=1 → sum=0x1FFFE (−2), overflow=0.
3. Positive overflow: a=0x7FFF, b=0x0001, sub=0 → overflow=1.
   - Without ADDSUB_SAT_EN: sum=0x08000.
   - With ADDSUB_SAT_EN: sum=0x07FFF.
4. Negative overflow: a=0x8000, b=0x0001, sub=1 → overflow=1.
   - Without ADDSUB_SAT_EN: sum=0x17FFF.
   - With ADDSUB_SAT_EN: sum=0x18000.
5. Control:
   - start and operand changes while busy have no effect on the result.
   - start held in the DONE cycle launches the next operation immediately; done is spaced 5 cycles apart.
   - rst_n=0 on the second RUN cycle → busy=0, sum=0, overflow=0, no done pulse.
6. Parameter sweep: WIDTH=8 with CHUNK=1 (done after 8 cycles) and CHUNK=8 (done after 1 cycle). Run 1000 random a/b/sub vectors each against a behavioural signed-arithmetic model, checking sum, overflow and latency.
